// File: rtl/bcp_sequencer.sv
// -----------------------------------------------------------------------------
// bcp_sequencer
// Sequences the hardware BCP check unit of the SAT engine:
//   - INIT  : streams CLAUSE_NUM clause records from clause memory into the
//             check unit, one record per cycle, then pulses init_done.
//   - READY : accepts backtrack requests and decisions, and owns the
//             assignment/free vectors.
//   - CHECK : fires a one-cycle check strobe with every clause slot enabled.
//   - WAIT  : applies the returned implication and re-checks, or reports a
//             fixpoint (bcp_done) or a conflict (bcp_conflict).
//
// Ports
//   clock, reset (async, active-low), start
//   mem_addr / mem_rdata                      clause memory read (1-cycle latency)
//   initial_signal, initial_mem, clause_en,
//   init_done                                 check-unit load interface
//   dec_valid, dec_ready, dec_var, dec_val    decision handshake
//   bt_valid, bt_mask                         backtrack request
//   free, assignment, imp_count               variable state
//   check_unit_request, chk_*                 check-unit request/response
//   bcp_done, bcp_conflict                    outcome pulses
//
// Optional feature macro: BCP_WATCHDOG_EN
//   When defined, a 4-bit watchdog in WAIT reports a conflict and returns to
//   READY if chk_valid is absent for 15 cycles (assignments are kept).
//   When undefined, WAIT holds indefinitely.
// -----------------------------------------------------------------------------
module bcp_sequencer #(
  parameter  int VAR_NUM    = 8,
  parameter  int CLAUSE_NUM = 8,
  localparam int VW         = $clog2(VAR_NUM),
  localparam int CW         = $clog2(CLAUSE_NUM)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [CW-1:0]         mem_addr,
  input  logic [23:0]           mem_rdata,
  output logic                  initial_signal,
  output logic [23:0]           initial_mem,
  output logic [CLAUSE_NUM-1:0] clause_en,
  output logic                  init_done,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [VW-1:0]         dec_var,
  input  logic                  dec_val,
  input  logic                  bt_valid,
  input  logic [VAR_NUM-1:0]    bt_mask,
  output logic [VAR_NUM-1:0]    free,
  output logic [VAR_NUM-1:0]    assignment,
  output logic                  check_unit_request,
  input  logic                  chk_valid,
  input  logic                  chk_unit,
  input  logic                  chk_conflict,
  input  logic [VW-1:0]         chk_imp_var,
  input  logic                  chk_imp_val,
  output logic                  bcp_done,
  output logic                  bcp_conflict,
  output logic [VW:0]           imp_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_READY = 3'd2,
    S_CHECK = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  localparam logic [CW-1:0]         ADDR_LAST = CW'(CLAUSE_NUM - 1);
  localparam logic [VW:0]           IMP_MAX   = (VW + 1)'(VAR_NUM);
  localparam logic [CLAUSE_NUM-1:0] ONE_C     = {{(CLAUSE_NUM - 1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [CW-1:0]         r_mem_addr;
  logic                  r_fetch_act;     // an address is being presented to clause memory
  logic                  r_initial_signal;
  logic [CLAUSE_NUM-1:0] r_clause_en;
  logic                  r_init_done;
  logic [VAR_NUM-1:0]    r_free;
  logic [VAR_NUM-1:0]    r_assignment;
  logic                  r_check_req;
  logic                  r_bcp_done;
  logic                  r_bcp_conflict;
  logic [VW:0]           r_imp_count;
`ifdef BCP_WATCHDOG_EN
  logic [3:0]            r_wd_cnt;
`endif

  logic [VAR_NUM-1:0]    w_free_bt;
  logic [VAR_NUM-1:0]    w_asg_bt;
  logic                  w_imp_free;
  logic                  w_imp_cur;
  logic [CLAUSE_NUM-1:0] w_onehot;

  // Post-backtrack vectors, one-hot load slot and implied-variable lookups
  always_comb begin
    w_free_bt = r_free;
    w_asg_bt  = r_assignment;
    if (bt_valid) begin
      w_free_bt = r_free | bt_mask;
      w_asg_bt  = r_assignment & ~bt_mask;
    end else begin
      w_free_bt = r_free;
      w_asg_bt  = r_assignment;
    end
    w_imp_free = r_free[chk_imp_var];
    w_imp_cur  = r_assignment[chk_imp_var];
    w_onehot   = ONE_C << r_mem_addr;
  end

  // Main sequencer FSM with all registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_mem_addr       <= {CW{1'b0}};
      r_fetch_act      <= 1'b0;
      r_initial_signal <= 1'b0;
      r_clause_en      <= {CLAUSE_NUM{1'b0}};
      r_init_done      <= 1'b0;
      r_free           <= {VAR_NUM{1'b1}};
      r_assignment     <= {VAR_NUM{1'b0}};
      r_check_req      <= 1'b0;
      r_bcp_done       <= 1'b0;
      r_bcp_conflict   <= 1'b0;
      r_imp_count      <= {(VW + 1){1'b0}};
`ifdef BCP_WATCHDOG_EN
      r_wd_cnt         <= 4'd0;
`endif
    end else begin
      // strobes and pulses are single-cycle unless re-asserted below
      r_init_done    <= 1'b0;
      r_check_req    <= 1'b0;
      r_bcp_done     <= 1'b0;
      r_bcp_conflict <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state          <= S_INIT;
            r_mem_addr       <= {CW{1'b0}};
            r_fetch_act      <= 1'b1;
            r_initial_signal <= 1'b0;
            r_clause_en      <= {CLAUSE_NUM{1'b0}};
            r_free           <= {VAR_NUM{1'b1}};
            r_assignment     <= {VAR_NUM{1'b0}};
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_INIT: begin
          // load stage trails the fetch stage by one cycle (memory latency)
          r_initial_signal <= r_fetch_act;
          r_clause_en      <= r_fetch_act ? w_onehot : {CLAUSE_NUM{1'b0}};
          if (r_fetch_act) begin
            if (r_mem_addr == ADDR_LAST) begin
              r_fetch_act <= 1'b0;
            end else begin
              r_mem_addr <= r_mem_addr + {{(CW - 1){1'b0}}, 1'b1};
            end
          end else begin
            r_fetch_act <= 1'b0;
          end
          // last load cycle: loading with no fetch behind it
          if (r_initial_signal && !r_fetch_act) begin
            r_init_done <= 1'b1;
          end else begin
            r_init_done <= 1'b0;
          end
          if (r_init_done) begin
            r_state    <= S_READY;
            r_mem_addr <= {CW{1'b0}};
          end else begin
            r_state <= S_INIT;
          end
        end

        S_READY: begin
          if (start) begin
            r_state          <= S_INIT;
            r_mem_addr       <= {CW{1'b0}};
            r_fetch_act      <= 1'b1;
            r_initial_signal <= 1'b0;
            r_clause_en      <= {CLAUSE_NUM{1'b0}};
            r_free           <= {VAR_NUM{1'b1}};
            r_assignment     <= {VAR_NUM{1'b0}};
          end else begin
            r_free       <= w_free_bt;
            r_assignment <= w_asg_bt;
            // later non-blocking writes let the decision bit override the backtrack
            if (dec_valid) begin
              r_free[dec_var]       <= 1'b0;
              r_assignment[dec_var] <= dec_val;
              r_imp_count           <= {(VW + 1){1'b0}};
              r_state               <= S_CHECK;
              r_check_req           <= 1'b1;
              r_clause_en           <= {CLAUSE_NUM{1'b1}};
            end else begin
              r_state <= S_READY;
            end
          end
        end

        S_CHECK: begin
          r_state     <= S_WAIT;
          r_clause_en <= {CLAUSE_NUM{1'b0}};
`ifdef BCP_WATCHDOG_EN
          r_wd_cnt    <= 4'd0;
`endif
        end

        S_WAIT: begin
          if (chk_valid) begin
            if (chk_conflict) begin
              r_bcp_conflict <= 1'b1;
              r_state        <= S_READY;
            end else if (chk_unit && w_imp_free) begin
              r_free[chk_imp_var]       <= 1'b0;
              r_assignment[chk_imp_var] <= chk_imp_val;
              if (r_imp_count != IMP_MAX) begin
                r_imp_count <= r_imp_count + {{VW{1'b0}}, 1'b1};
              end else begin
                r_imp_count <= r_imp_count;
              end
              r_state     <= S_CHECK;
              r_check_req <= 1'b1;
              r_clause_en <= {CLAUSE_NUM{1'b1}};
            end else if (chk_unit && (w_imp_cur != chk_imp_val)) begin
              r_bcp_conflict <= 1'b1;
              r_state        <= S_READY;
            end else begin
              // no unit, or a unit already satisfied: fixpoint (avoids livelock)
              r_bcp_done <= 1'b1;
              r_state    <= S_READY;
            end
          end else begin
`ifdef BCP_WATCHDOG_EN
            if (r_wd_cnt == 4'd14) begin
              r_bcp_conflict <= 1'b1;
              r_state        <= S_READY;
              r_wd_cnt       <= 4'd0;
            end else begin
              r_wd_cnt <= r_wd_cnt + 4'd1;
              r_state  <= S_WAIT;
            end
`else
            r_state <= S_WAIT;
`endif
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr           = r_mem_addr;
  assign initial_signal     = r_initial_signal;
  assign initial_mem        = r_initial_signal ? mem_rdata : 24'h000000;
  assign clause_en          = r_clause_en;
  assign init_done          = r_init_done;
  assign dec_ready          = (r_state == S_READY) && !start;
  assign free               = r_free;
  assign assignment         = r_assignment;
  assign check_unit_request = r_check_req;
  assign bcp_done           = r_bcp_done;
  assign bcp_conflict       = r_bcp_conflict;
  assign imp_count          = r_imp_count;

endmodule

// File: tb/tb_bcp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bcp_sequencer
// Directed stimulus pushes expected output events into a queue; a monitor on
// the falling clock edge pops and compares whenever the DUT presents a load
// strobe, init_done, a check request, or a done/conflict pulse.
// -----------------------------------------------------------------------------
module tb_bcp_sequencer;

  localparam int VN = 8;
  localparam int CN = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mem_addr;
  logic [23:0] mem_rdata;
  logic        initial_signal;
  logic [23:0] initial_mem;
  logic [7:0]  clause_en;
  logic        init_done;
  logic        dec_valid;
  logic        dec_ready;
  logic [2:0]  dec_var;
  logic        dec_val;
  logic        bt_valid;
  logic [7:0]  bt_mask;
  logic [7:0]  free;
  logic [7:0]  assignment;
  logic        check_unit_request;
  logic        chk_valid;
  logic        chk_unit;
  logic        chk_conflict;
  logic [2:0]  chk_imp_var;
  logic        chk_imp_val;
  logic        bcp_done;
  logic        bcp_conflict;
  logic [3:0]  imp_count;

  bcp_sequencer #(.VAR_NUM(VN), .CLAUSE_NUM(CN)) dut (
    .clock(clock), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .initial_signal(initial_signal), .initial_mem(initial_mem),
    .clause_en(clause_en), .init_done(init_done),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_var(dec_var), .dec_val(dec_val),
    .bt_valid(bt_valid), .bt_mask(bt_mask),
    .free(free), .assignment(assignment),
    .check_unit_request(check_unit_request),
    .chk_valid(chk_valid), .chk_unit(chk_unit), .chk_conflict(chk_conflict),
    .chk_imp_var(chk_imp_var), .chk_imp_val(chk_imp_val),
    .bcp_done(bcp_done), .bcp_conflict(bcp_conflict), .imp_count(imp_count)
  );

  always #5 clock = ~clock;

  // clause memory model: word k = 24'h0k0k0k, one cycle read latency
  always @(posedge clock) begin
    mem_rdata <= {5'b00000, mem_addr, 5'b00000, mem_addr, 5'b00000, mem_addr};
  end

  typedef enum int {EV_NONE, EV_LOAD, EV_INITD, EV_REQ, EV_DONE, EV_CONF, EV_BOTH} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  en;
    logic [23:0] mem;
    logic [7:0]  asg;
    logic [7:0]  fr;
    logic [3:0]  imp;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_act;
  ev_t mon_exp;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [7:0] en, input logic [23:0] mem,
                      input logic [7:0] asg, input logic [7:0] fr, input logic [3:0] imp);
    ev_t e;
    e.kind = k; e.en = en; e.mem = mem; e.asg = asg; e.fr = fr; e.imp = imp;
    exp_q.push_back(e);
  endtask

  // monitor: classify the DUT's output event this cycle and score it
  always @(negedge clock) begin
    mon_act.kind = EV_NONE;
    if (initial_signal)                 mon_act.kind = EV_LOAD;
    else if (init_done)                 mon_act.kind = EV_INITD;
    else if (check_unit_request)        mon_act.kind = EV_REQ;
    else if (bcp_done && bcp_conflict)  mon_act.kind = EV_BOTH;
    else if (bcp_done)                  mon_act.kind = EV_DONE;
    else if (bcp_conflict)              mon_act.kind = EV_CONF;
    mon_act.en  = clause_en;
    mon_act.mem = initial_mem;
    mon_act.asg = assignment;
    mon_act.fr  = free;
    mon_act.imp = imp_count;
    if (mon_act.kind != EV_NONE) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", mon_act.kind, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("event_kind", mon_act.kind, mon_exp.kind);
        if (mon_act.kind == mon_exp.kind) begin
          case (mon_exp.kind)
            EV_LOAD: begin
              chk("load_clause_en", mon_act.en, mon_exp.en);
              chk("load_initial_mem", mon_act.mem, mon_exp.mem);
            end
            EV_REQ:  chk("req_clause_en", mon_act.en, mon_exp.en);
            EV_DONE, EV_CONF: begin
              chk("out_assignment", mon_act.asg, mon_exp.asg);
              chk("out_free", mon_act.fr, mon_exp.fr);
              chk("out_imp_count", mon_act.imp, mon_exp.imp);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // issue a decision (optionally with a same-cycle backtrack); returns in WAIT
  task automatic decide(input int v, input bit val, input bit bt, input logic [7:0] mask);
    push(EV_REQ, 8'hFF, 24'h0, 8'h0, 8'h0, 4'h0);
    chk("dec_ready_in_ready", dec_ready, 1'b1);
    dec_valid = 1'b1; dec_var = v[2:0]; dec_val = val;
    bt_valid  = bt;   bt_mask = mask;
    @(negedge clock);
    dec_valid = 1'b0; bt_valid = 1'b0; bt_mask = 8'h00;
    @(negedge clock);
  endtask

  // one check-unit response; the resulting event is visible on return
  task automatic respond(input bit unit, input bit conf, input int v, input bit val);
    chk_valid = 1'b1; chk_unit = unit; chk_conflict = conf;
    chk_imp_var = v[2:0]; chk_imp_val = val;
    @(negedge clock);
    chk_valid = 1'b0; chk_unit = 1'b0; chk_conflict = 1'b0;
  endtask

  initial begin
    int first_is;
    int n_is;
    int done_at;
    int rdy_at;
    reset = 1'b0; start = 1'b0;
    dec_valid = 1'b0; dec_var = 3'd0; dec_val = 1'b0;
    bt_valid = 1'b0; bt_mask = 8'h00;
    chk_valid = 1'b0; chk_unit = 1'b0; chk_conflict = 1'b0;
    chk_imp_var = 3'd0; chk_imp_val = 1'b0;
    repeat (3) @(negedge clock);

    // reset state
    chk("rst_free", free, 8'hFF);
    chk("rst_assignment", assignment, 8'h00);
    chk("rst_imp_count", imp_count, 4'h0);
    chk("rst_mem_addr", mem_addr, 3'd0);
    chk("rst_clause_en", clause_en, 8'h00);
    chk("rst_dec_ready", dec_ready, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    // initialisation: 8 loads walking clause_en, then init_done
    for (int k = 0; k < CN; k++) begin
      logic [7:0] w;
      w = 8'(k);
      push(EV_LOAD, 8'h01 << k, {w, w, w}, 8'h0, 8'h0, 4'h0);
    end
    push(EV_INITD, 8'h0, 24'h0, 8'h0, 8'h0, 4'h0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    first_is = -1; n_is = 0; done_at = -1; rdy_at = -1;
    for (int i = 1; i <= 14; i++) begin
      if (initial_signal) begin
        if (first_is < 0) first_is = i;
        n_is++;
      end
      if (init_done && done_at < 0) done_at = i;
      if (dec_ready && rdy_at < 0) rdy_at = i;
      @(negedge clock);
    end
    chk("init_first_load_cycle", first_is, 2);
    chk("init_load_count", n_is, 8);
    chk("init_done_cycle", done_at, 10);
    chk("dec_ready_rise_cycle", rdy_at, 11);

    // chk_valid in READY must be ignored
    chk_valid = 1'b1; chk_unit = 1'b1; chk_imp_var = 3'd4; chk_imp_val = 1'b1;
    @(negedge clock);
    chk_valid = 1'b0; chk_unit = 1'b0;
    chk("ignored_chk_free", free, 8'hFF);

    // decision var3=1, no unit
    decide(3, 1'b1, 1'b0, 8'h00);
    push(EV_DONE, 8'h0, 24'h0, 8'h08, 8'hF7, 4'd0);
    respond(1'b0, 1'b0, 0, 1'b0);

    // backtrack var3 alone
    bt_valid = 1'b1; bt_mask = 8'h08;
    @(negedge clock);
    bt_valid = 1'b0; bt_mask = 8'h00;
    chk("bt_free", free, 8'hFF);
    chk("bt_assignment", assignment, 8'h00);

    // decision var0=0, implications var5=1, var6=0, then fixpoint
    decide(0, 1'b0, 1'b0, 8'h00);
    push(EV_REQ, 8'hFF, 24'h0, 8'h0, 8'h0, 4'h0);
    respond(1'b1, 1'b0, 5, 1'b1);
    @(negedge clock);
    push(EV_REQ, 8'hFF, 24'h0, 8'h0, 8'h0, 4'h0);
    respond(1'b1, 1'b0, 6, 1'b0);
    @(negedge clock);
    push(EV_DONE, 8'h0, 24'h0, 8'h20, 8'h9E, 4'd2);
    respond(1'b0, 1'b0, 0, 1'b0);

    // decision var2=0, implication var2=1 -> conflict
    decide(2, 1'b0, 1'b0, 8'h00);
    push(EV_CONF, 8'h0, 24'h0, 8'h20, 8'h9A, 4'd0);
    respond(1'b1, 1'b0, 2, 1'b1);

    // decision var1=1, implication var1=1 (same value) -> done
    decide(1, 1'b1, 1'b0, 8'h00);
    push(EV_DONE, 8'h0, 24'h0, 8'h22, 8'h98, 4'd0);
    respond(1'b1, 1'b0, 1, 1'b1);

    // decision var3=1, conflict and unit together -> conflict only
    decide(3, 1'b1, 1'b0, 8'h00);
    push(EV_CONF, 8'h0, 24'h0, 8'h2A, 8'h90, 4'd0);
    respond(1'b1, 1'b1, 7, 1'b1);

    // backtrack mask 0x0C with decision var2=1 in the same cycle
    decide(2, 1'b1, 1'b1, 8'h0C);
    push(EV_DONE, 8'h0, 24'h0, 8'h26, 8'h98, 4'd0);
    respond(1'b0, 1'b0, 0, 1'b0);

    // decision var7=1, implication var4=1, then reset while waiting
    decide(7, 1'b1, 1'b0, 8'h00);
    push(EV_REQ, 8'hFF, 24'h0, 8'h0, 8'h0, 4'h0);
    respond(1'b1, 1'b0, 4, 1'b1);
    @(negedge clock);
    chk("pre_reset_imp_count", imp_count, 4'd1);
    reset = 1'b0;
    #1;
    chk("midrst_free", free, 8'hFF);
    chk("midrst_assignment", assignment, 8'h00);
    chk("midrst_imp_count", imp_count, 4'd0);
    chk("midrst_req", check_unit_request, 1'b0);
    chk("midrst_pulses", {bcp_done, bcp_conflict, init_done, initial_signal}, 4'b0000);
    chk("midrst_dec_ready", dec_ready, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    dec_valid = 1'b1; dec_var = 3'd5; dec_val = 1'b1;
    @(negedge clock);
    chk("idle_dec_ready", dec_ready, 1'b0);
    chk("idle_free", free, 8'hFF);
    dec_valid = 1'b0;

    // drain remaining expectations (bounded)
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcp_sequencer.md
Name: bcp_sequencer

Overview:
- Controller that sequences the hardware BCP check unit for the SAT engine.
- At start-up it loads clause records from clause memory into the check unit, one clause per cycle.
- It then takes decisions from the decision engine and owns the assignment/free vectors.
- It repeatedly fires check requests and applies the returned implications until a fixpoint (done) or a conflict, and reports the outcome.

Parameters:
- VAR_NUM, 8, number of variables; width of free/assignment.
- CLAUSE_NUM, 8, number of clause slots in the check unit.
- VW, $clog2(VAR_NUM), variable index width (derived, not overridable).
- CW, $clog2(CLAUSE_NUM), clause address width (derived).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin (re)initialisation of the check unit.
- mem_addr  out  CW  clause memory read address.
- mem_rdata  in  24  clause record {type[23:16], mask[15:8], size[7:0]}; valid 1 cycle after mem_addr.
- initial_signal  out  1  clause load strobe to the check unit.
- initial_mem  out  24  clause record being loaded.
- clause_en  out  CLAUSE_NUM  one-hot target slot during load; all ones during check.
- init_done  out  1  1-cycle pulse when the load completes.
- dec_valid  in  1  decision valid.
- dec_ready  out  1  decision accepted when high with dec_valid.
- dec_var  in  VW  decided variable index.
- dec_val  in  1  decided polarity.
- bt_valid  in  1  backtrack request.
- bt_mask  in  VAR_NUM  variables to unassign.
- free  out  VAR_NUM  1 = variable unassigned.
- assignment  out  VAR_NUM  current values.
- check_unit_request  out  1  1-cycle check strobe.
- chk_valid  in  1  check result valid.
- chk_unit  in  1  a unit clause exists.
- chk_conflict  in  1  a clause is falsified.
- chk_imp_var  in  VW  implied variable.
- chk_imp_val  in  1  implied polarity.
- bcp_done  out  1  1-cycle pulse: propagation reached a fixpoint.
- bcp_conflict  out  1  1-cycle pulse: conflict detected.
- imp_count  out  VW+1  implications applied since the last accepted decision; saturates at VAR_NUM.

Behaviour:
- Reset (asynchronous): state IDLE; free all ones; assignment, imp_count, and all strobes/pulses 0; mem_addr 0; clause_en 0.
- States: IDLE, INIT, READY, CHECK, WAIT.
- IDLE → INIT on start.
- In INIT:
  - mem_addr counts 0..CLAUSE_NUM-1, one address per cycle.
  - A registered copy of the address feeds the load stage. The cycle after address k: initial_signal=1, initial_mem=mem_rdata, clause_en=onehot(k).
  - The last load cycle is start accepted + CLAUSE_NUM + 1.
  - The next cycle: init_done pulses and the state moves to READY.
  - free is set to all ones and assignment cleared on entry to INIT.
- In READY, priority is start > bt_valid > decision.
  - start: re-enter INIT. dec_ready is 0 in that cycle.
  - bt_valid: free |= bt_mask and assignment &= ~bt_mask in the same edge. A simultaneous accepted decision is applied after the backtrack (the decision bit wins).
  - dec_ready = (state==READY) & !start.
  - On handshake: assignment[dec_var]<=dec_val, free[dec_var]<=0, imp_count<=0, go to CHECK. There is no legality check on already-assigned variables.
- CHECK: check_unit_request=1 and clause_en all ones for exactly one cycle, then WAIT.
- WAIT holds until chk_valid. When chk_valid arrives:
  - chk_conflict=1 (has priority over chk_unit): bcp_conflict pulse, go to READY.
  - chk_unit=1 with free[chk_imp_var]=1: assign the implied variable, imp_count++ (saturating), go to CHECK.
  - chk_unit=1 with the variable already assigned to the opposite value: bcp_conflict pulse, go to READY.
  - chk_unit=1 with the variable already assigned to the same value: bcp_done pulse, go to READY (prevents a livelock).
  - chk_unit=0: bcp_done pulse, go to READY.
- Latency: decision handshake → check_unit_request is 1 cycle. chk_valid → next check_unit_request is 1 cycle.
- Ignored inputs:
  - bt_valid, dec_valid, and start are ignored outside READY/IDLE.
  - chk_valid is ignored outside WAIT.
- Reset mid-operation aborts immediately to the reset state. No pulses are emitted.

Optional Feature:
- BCP_WATCHDOG_EN defined: a 4-bit counter runs in WAIT.
  - If chk_valid is absent for 15 cycles: bcp_conflict pulses and the state returns to READY.
  - Assignments made so far are kept.
- Undefined: WAIT holds indefinitely.

Test Plan:
- Init with CLAUSE_NUM=8, memory word k = 24'h0k0k0k, start pulse:
  - initial_signal high for 8 consecutive cycles.
  - clause_en walks 01→80 with matching initial_mem.
  - init_done pulses once; dec_ready rises the next cycle.
- Decision var3=1, check unit answers no unit:
  - assignment=08, free=F7, one check_unit_request, bcp_done pulse, imp_count=0.
- Decision var0=0, unit implications var5=1 then var6=0, then no unit:
  - 3 check requests; assignment=20, free=9E; imp_count=2; bcp_done.
- Implication var2=1 while var2 is already assigned 0 → bcp_conflict, no bcp_done.
- Response with chk_conflict=1 and chk_unit=1 both high → bcp_conflict only.
- bt_valid with mask=0x0C and a decision on var2=1 in the same READY cycle:
  - var3 freed; var2 assigned 1.
- Reset asserted during WAIT:
  - free=FF, all outputs 0, state IDLE, dec_ready=0.
